uart_rx_fifo: RTL and testbench

- Buffers bytes from the UART receiver (o_RX_DV / o_RX_Byte) and presents them to the 68000 bus glue.
- Replaces the single rx_data / rxf_n holding register, which loses bytes when software polls slowly.
- Sits between UART_RX and the bus address decoder. It supplies the byte returned at the RX data address and the rxf_n flag returned at the RX status address.
- Pops exactly one byte per 68000 read bus cycle, however many clk12 cycles that bus cycle lasts.

---
 rtl/m68k_pkg.sv | 20 ++
 rtl/uart_rx_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_pkg.sv
// Shared 68000 bus definitions: decoded register addresses and the byte type
// passed between the UART, its receive FIFO and the bus glue.
package m68k_pkg;

    localparam logic [22:0] ADDR_RX_DATA   = 23'h03c000;
    localparam logic [22:0] ADDR_TX_DATA   = 23'h03d000;
    localparam logic [22:0] ADDR_RXF_STAT  = 23'h03e000;
    localparam logic [22:0] ADDR_TXE_STAT  = 23'h03e800;

    typedef logic [7:0] byte_t;

    function automatic logic is_rx_data(input logic [22:0] addr);
        return addr == ADDR_RX_DATA;
    endfunction

    function automatic logic is_rxf_stat(input logic [22:0] addr);
        return addr == ADDR_RXF_STAT;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 8 storage with one write port and an asynchronous read port, kept
// separate so it can later be mapped onto iCE40 LUT-RAM or BRAM.
module fifo_mem
    import m68k_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem_q [DEPTH];

    // Contents are deliberately left unreset so the array stays RAM-mappable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between UART_RX and the 68000 bus glue: show-ahead registered
// read data, one pop per bus read cycle, sticky overflow/underflow flags.
module uart_rx_fifo
    import m68k_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk12,
    input  logic          RSTn,
    input  logic          rx_dv,
    input  byte_t         rx_byte,
    input  logic          rd_strobe,
    input  logic          clr_ovf,
    output byte_t         rd_data,
    output logic          rxf_n,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          unf
);

    // Handshake: rx_dv is a single-cycle strobe with no back-pressure (a byte
    // offered while full is lost and flagged); rd_strobe is a level held for
    // the whole bus read, and only its first cycle consumes an entry.

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          rxf_n_q, rxf_n_d;
    byte_t         rd_data_q, rd_data_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          stb_hist_q, stb_hist_d;
    logic          armed_q, armed_d;

    logic          pop_evt;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    byte_t         head_data;

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk12),
        .we    (do_push),
        .waddr (wr_ptr_q),
        .wdata (rx_byte),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    always_comb begin
        // armed_q blocks a pop until the strobe has been seen low once after
        // reset, so a bus read still in progress at release is not consumed.
        pop_evt    = rd_strobe & ~stb_hist_q & armed_q;
        empty      = (level_q == '0);
        full       = (level_q == LVL_FULL);
        do_pop     = pop_evt & ~empty;
        do_push    = rx_dv & (~full | pop_evt);

        stb_hist_d = rd_strobe;
        armed_d    = armed_q | ~rd_strobe;

        rd_ptr_d   = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        rxf_n_d = (level_d == '0);

        // Frozen for the whole strobe; otherwise track the head, forwarding a
        // byte written into an empty FIFO so it shows up with the level change.
        rd_data_d = rd_data_q;
        if (!rd_strobe) begin
            if (!empty) begin
                rd_data_d = head_data;
            end else if (rx_dv) begin
                rd_data_d = rx_byte;
            end else begin
                rd_data_d = 8'h00;
            end
        end

        // A set event in the same cycle as clr_ovf wins.
        ovf_d = ovf_q;
        if (rx_dv && full && !pop_evt) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (pop_evt && empty) begin
            unf_d = 1'b1;
        end else if (clr_ovf) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk12 or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            rxf_n_q    <= 1'b1;
            rd_data_q  <= 8'h00;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            stb_hist_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            rxf_n_q    <= rxf_n_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            stb_hist_q <= stb_hist_d;
            armed_q    <= armed_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rxf_n   = rxf_n_q;
    assign level   = level_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table vectors, hand sequences for full/reset corners
// and randomized interleaved traffic against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk12 = 1'b0;
    logic       RSTn;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rd_strobe;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       rxf_n;
    logic [4:0] level;
    logic       ovf;
    logic       unf;

    always #5 clk12 = ~clk12;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk12     (clk12),
        .RSTn      (RSTn),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .rd_strobe (rd_strobe),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .rxf_n     (rxf_n),
        .level     (level),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic       stb;
        logic       clr;
        logic [4:0] lvl;
        logic       rxfn;
        logic [7:0] dat;
        logic       ov;
        logic       un;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;

    // Behavioural model: a queue of stored bytes plus the visible registers.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_ovf;
    logic       m_unf;
    logic       m_prev;
    logic       m_armed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_data  = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic m_update(input logic dv, input logic [7:0] b, input logic stb, input logic clr);
        logic pop;
        logic was_empty;
        logic was_full;
        pop       = stb && !m_prev && m_armed;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        if (pop && !was_empty) void'(mq.pop_front());
        if (dv && (!was_full || pop)) mq.push_back(b);
        if (!stb) m_data = (mq.size() > 0) ? mq[0] : 8'h00;
        if (dv && was_full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop && was_empty) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        m_armed = m_armed || !stb;
        m_prev  = stb;
    endtask

    task automatic tick(input logic dv, input logic [7:0] b, input logic stb, input logic clr);
        rx_dv     = dv;
        rx_byte   = b;
        rd_strobe = stb;
        clr_ovf   = clr;
        @(posedge clk12);
        m_update(dv, b, stb, clr);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_level"}, 32'(level),   32'(mq.size()));
        chk({tag, "_rxf_n"}, 32'(rxf_n),   32'(mq.size() == 0));
        chk({tag, "_data"},  32'(rd_data), 32'(m_data));
        chk({tag, "_ovf"},   32'(ovf),     32'(m_ovf));
        chk({tag, "_unf"},   32'(unf),     32'(m_unf));
    endtask

    task automatic step(input logic dv, input logic [7:0] b, input logic stb, input logic clr,
                        input string tag);
        tick(dv, b, stb, clr);
        check_model(tag);
    endtask

    task automatic do_read(output logic [7:0] got);
        step(1'b0, 8'h00, 1'b1, 1'b0, "rd");
        got = rd_data;
        step(1'b0, 8'h00, 1'b0, 1'b0, "rd_idle");
    endtask

    task automatic do_reset();
        RSTn      = 1'b0;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        rd_strobe = 1'b0;
        clr_ovf   = 1'b0;
        m_reset();
        repeat (2) @(posedge clk12);
        #1;
        check_model("rst");
        RSTn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vt[16];
        logic [7:0] got;
        logic [7:0] e;
        logic       dv;
        logic [7:0] nb;
        int         pushed;
        int         iter;
        int         len;

        // Reset values checked against constants.
        RSTn      = 1'b0;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        rd_strobe = 1'b0;
        clr_ovf   = 1'b0;
        m_reset();
        repeat (2) @(posedge clk12);
        #1;
        chk("reset_level", 32'(level),   32'd0);
        chk("reset_rxf_n", 32'(rxf_n),   32'd1);
        chk("reset_data",  32'(rd_data), 32'h00);
        chk("reset_ovf",   32'(ovf),     32'd0);
        chk("reset_unf",   32'(unf),     32'd0);
        RSTn = 1'b1;

        // dv, byte, stb, clr -> level, rxf_n, rd_data, ovf, unf after the edge
        vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[12] = '{1'b1, 8'h3C, 1'b1, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            tick(vt[i].dv, vt[i].b, vt[i].stb, vt[i].clr);
            chk($sformatf("v%0d_level", i), 32'(level),   32'(vt[i].lvl));
            chk($sformatf("v%0d_rxf_n", i), 32'(rxf_n),   32'(vt[i].rxfn));
            chk($sformatf("v%0d_data", i),  32'(rd_data), 32'(vt[i].dat));
            chk($sformatf("v%0d_ovf", i),   32'(ovf),     32'(vt[i].ov));
            chk($sformatf("v%0d_unf", i),   32'(unf),     32'(vt[i].un));
        end

        // Fill, overflow, drain in order, clear.
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'h11, 1'b0, 1'b0, "ovf_push");
        chk("full_level", 32'(level), 32'd16);
        chk("full_ovf",   32'(ovf),   32'd1);
        for (int i = 1; i <= 16; i++) begin
            do_read(got);
            chk($sformatf("drain_%0d", i), 32'(got), 32'(i));
        end
        chk("drain_rxf_n", 32'(rxf_n), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Push into a full FIFO on the same cycle as a pop.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, "fill2");
        step(1'b1, 8'h77, 1'b1, 1'b0, "full_pushpop");
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf",   32'(ovf),   32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, "pp_idle");
        for (int i = 0; i < 16; i++) do_read(got);
        chk("pp_last", 32'(got), 32'h77);

        // Randomized interleaved traffic, level kept within 0..3.
        do_reset();
        exp_q.delete();
        pushed = 0;
        iter   = 0;
        while ((pushed < 40 || exp_q.size() > 0) && iter < 2000) begin
            iter++;
            dv = (pushed < 40 && mq.size() < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            nb = 8'($urandom);
            if (mq.size() > 0 && ($urandom_range(0, 2) == 0 || pushed >= 40 || mq.size() >= 3)) begin
                e = exp_q.pop_front();
                if (dv) begin
                    exp_q.push_back(nb);
                    pushed++;
                end
                step(dv, nb, 1'b1, 1'b0, "rnd_rd");
                chk("sb_data", 32'(rd_data), 32'(e));
                len = $urandom_range(0, 2);
                for (int k = 0; k < len; k++) step(1'b0, 8'h00, 1'b1, 1'b0, "rnd_hold");
                step(1'b0, 8'h00, 1'b0, 1'b0, "rnd_low");
            end else begin
                if (dv) begin
                    exp_q.push_back(nb);
                    pushed++;
                end
                step(dv, nb, 1'b0, 1'b0, "rnd_push");
            end
        end
        chk("rnd_pushed", 32'(pushed), 32'd40);
        chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted while a strobe is high and level is 5.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rd");
        chk("pre_level", 32'(level), 32'd5);
        RSTn = 1'b0;
        #2;
        m_reset();
        chk("async_level", 32'(level),   32'd0);
        chk("async_rxf_n", 32'(rxf_n),   32'd1);
        chk("async_data",  32'(rd_data), 32'h00);
        @(posedge clk12);
        #1;
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "post_hold");
        chk("post_level", 32'(level), 32'd0);
        chk("post_unf",   32'(unf),   32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, "post_low");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rise");
        chk("post_rise_unf", 32'(unf), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
